step_dir_gen: RTL

//  Step/dir pulse generator: the initiator side of the stepper step/dir interface.

---
 rtl/step_dir_gen.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/step_dir_gen.sv
`default_nettype none
// ============================================================================
//  Module   : step_dir_gen
//  Brief    : Step/dir pulse generator with dir-setup and pulse-width timing.
//             Optional signed position counter under STEP_DIR_POSITION_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module step_dir_gen #(
    parameter int CNT_W           = 32,
    parameter int TICK_W          = 32,
    parameter int PULSE_TICKS     = 8,
    parameter int DIR_SETUP_TICKS = 16
`ifdef STEP_DIR_POSITION_EN
    ,
    parameter int POS_W           = 32
`endif
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              move_valid,
    output logic              move_ready,
    input  logic              move_dir,
    input  logic [CNT_W-1:0]  move_steps,
    input  logic [TICK_W-1:0] move_period,
    input  logic              abort,
    output logic              step,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  steps_remaining
`ifdef STEP_DIR_POSITION_EN
    ,
    output logic signed [POS_W-1:0] position
`endif
);

    localparam logic [2:0] c_IDLE      = 3'd0;
    localparam logic [2:0] c_DIR_SETUP = 3'd1;
    localparam logic [2:0] c_STEP_HI   = 3'd2;
    localparam logic [2:0] c_STEP_LO   = 3'd3;
    localparam logic [2:0] c_DONE      = 3'd4;

    localparam logic [TICK_W-1:0] c_PULSE      = TICK_W'(PULSE_TICKS);
    localparam logic [TICK_W-1:0] c_PULSE_LOAD = TICK_W'(PULSE_TICKS - 1);
    localparam logic [TICK_W-1:0] c_SETUP_LOAD = TICK_W'(DIR_SETUP_TICKS - 1);
    localparam logic [TICK_W-1:0] c_MIN_PERIOD = TICK_W'(PULSE_TICKS + 1);

    logic [2:0]        r_state;
    logic [TICK_W-1:0] r_tick;
    logic [TICK_W-1:0] r_lo_load;
    logic [CNT_W-1:0]  r_steps;
    logic              r_dir;
    logic              r_abort_pend;
    logic              r_step;
    logic              r_busy;
    logic              r_done;
    logic              r_ready;

    logic [2:0]        w_state_nxt;
    logic [TICK_W-1:0] w_tick_nxt;
    logic [TICK_W-1:0] w_lo_load_nxt;
    logic [CNT_W-1:0]  w_steps_nxt;
    logic              w_dir_nxt;
    logic              w_abort_pend_nxt;
    logic              w_rise;
    logic [TICK_W-1:0] w_eff_period;

    assign w_eff_period = (move_period < c_MIN_PERIOD) ? c_MIN_PERIOD : move_period;

    always_comb begin
        w_state_nxt      = r_state;
        w_tick_nxt       = r_tick;
        w_lo_load_nxt    = r_lo_load;
        w_steps_nxt      = r_steps;
        w_dir_nxt        = r_dir;
        w_abort_pend_nxt = r_abort_pend;
        w_rise           = 1'b0;
        case (r_state)
            c_IDLE: begin
                w_abort_pend_nxt = 1'b0;
                if (move_valid && r_ready) begin
                    // Tick counters reload with (cycles - 1) since the load cycle counts.
                    w_lo_load_nxt = w_eff_period - c_PULSE - TICK_W'(1);
                    w_steps_nxt   = move_steps;
                    if (move_steps == '0) begin
                        w_state_nxt = c_DONE;
                    end else if (move_dir != r_dir) begin
                        w_state_nxt = c_DIR_SETUP;
                        w_dir_nxt   = move_dir;
                        w_tick_nxt  = c_SETUP_LOAD;
                    end else begin
                        w_state_nxt = c_STEP_HI;
                        w_tick_nxt  = c_PULSE_LOAD;
                        w_steps_nxt = move_steps - CNT_W'(1);
                        w_rise      = 1'b1;
                    end
                end
            end
            c_DIR_SETUP: begin
                if (abort) begin
                    w_state_nxt = c_DONE;
                end else if (r_tick == '0) begin
                    w_state_nxt = c_STEP_HI;
                    w_tick_nxt  = c_PULSE_LOAD;
                    w_steps_nxt = r_steps - CNT_W'(1);
                    w_rise      = 1'b1;
                end else begin
                    w_tick_nxt = r_tick - TICK_W'(1);
                end
            end
            c_STEP_HI: begin
                // An abort here is remembered so the pulse keeps its full width.
                if (abort) begin
                    w_abort_pend_nxt = 1'b1;
                end
                if (r_tick == '0) begin
                    if (abort || r_abort_pend) begin
                        w_state_nxt = c_DONE;
                    end else begin
                        w_state_nxt = c_STEP_LO;
                        w_tick_nxt  = r_lo_load;
                    end
                end else begin
                    w_tick_nxt = r_tick - TICK_W'(1);
                end
            end
            c_STEP_LO: begin
                if (abort) begin
                    w_state_nxt = c_DONE;
                end else if (r_tick == '0) begin
                    if (r_steps != '0) begin
                        w_state_nxt = c_STEP_HI;
                        w_tick_nxt  = c_PULSE_LOAD;
                        w_steps_nxt = r_steps - CNT_W'(1);
                        w_rise      = 1'b1;
                    end else begin
                        w_state_nxt = c_DONE;
                    end
                end else begin
                    w_tick_nxt = r_tick - TICK_W'(1);
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_tick       <= '0;
            r_lo_load    <= '0;
            r_steps      <= '0;
            r_dir        <= 1'b0;
            r_abort_pend <= 1'b0;
            r_step       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_ready      <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_tick       <= w_tick_nxt;
            r_lo_load    <= w_lo_load_nxt;
            r_steps      <= w_steps_nxt;
            r_dir        <= w_dir_nxt;
            r_abort_pend <= w_abort_pend_nxt;
            r_step       <= (w_state_nxt == c_STEP_HI);
            r_busy       <= (w_state_nxt != c_IDLE);
            r_done       <= (w_state_nxt == c_DONE);
            r_ready      <= (w_state_nxt == c_IDLE);
        end
    end

`ifdef STEP_DIR_POSITION_EN
    logic signed [POS_W-1:0] r_pos;

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_pos <= '0;
        end else if (w_rise) begin
            r_pos <= w_dir_nxt ? (r_pos + POS_W'(1)) : (r_pos - POS_W'(1));
        end
    end

    assign position = r_pos;
`endif

    assign move_ready      = r_ready;
    assign step            = r_step;
    assign dir             = r_dir;
    assign busy            = r_busy;
    assign done            = r_done;
    assign steps_remaining = r_steps;

endmodule
`default_nettype wire
